// File: rtl/regfile_writeback_if.sv
// Memory / long-latency result channel into the register-file write-back stage.
// The producer drives a result with valid and holds it stable until ready is seen.
interface regfile_writeback_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;

    modport master (
        output mem_valid,
        output mem_rd,
        output mem_data,
        input  mem_ready
    );

    modport slave (
        input  mem_valid,
        input  mem_rd,
        input  mem_data,
        output mem_ready
    );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU results and buffered memory results into the
// single register-file write port and tracks pending long-latency destinations.
// ALU results always win the port; memory results wait in a small FIFO.
// Optional feature: define WB_BYPASS_EN to add write-port forwarding outputs
// (fwd1_valid/fwd1_data, fwd2_valid/fwd2_data) that also mask busy1/busy2.
module regfile_writeback #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [4:0]                    alu_rd,
    input  logic [31:0]                   alu_data,
    regfile_writeback_if.slave            mem,
    input  logic                          pend_set,
    input  logic [4:0]                    pend_rd,
    input  logic [4:0]                    srcreg1_num,
    input  logic [4:0]                    srcreg2_num,
    output logic                          busy1,
    output logic                          busy2,
    output logic                          reg_we,
    output logic [4:0]                    dstreg_num,
    output logic [31:0]                   write_value,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef WB_BYPASS_EN
    ,
    output logic                          fwd1_valid,
    output logic [31:0]                   fwd1_data,
    output logic                          fwd2_valid,
    output logic [31:0]                   fwd2_data
`endif
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned REG_N  = 32;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    wb_entry_t              fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    wb_entry_t              head;
    logic                   out_is_mem;
    logic [REG_N-1:0]       scoreboard;
    logic [REG_N-1:0]       scoreboard_next;

    // FIFO status and handshake decode
    always_comb begin
        fifo_full     = (fifo_count == CNT_W'(FIFO_DEPTH));
        fifo_empty    = (fifo_count == '0);
        mem.mem_ready = !fifo_full;
        push          = mem.mem_valid && !fifo_full;
        pop           = !alu_valid && !fifo_empty;
        head          = fifo_mem[rd_ptr];
    end

    // FIFO storage: payload only, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{rd: mem.mem_rd, data: mem.mem_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Write-port register: ALU first, then FIFO head, else idle; x0 never writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_we      <= 1'b0;
            dstreg_num  <= '0;
            write_value <= '0;
            out_is_mem  <= 1'b0;
        end else if (alu_valid) begin
            reg_we      <= (alu_rd != 5'd0);
            dstreg_num  <= alu_rd;
            write_value <= alu_data;
            out_is_mem  <= 1'b0;
        end else if (pop) begin
            reg_we      <= (head.rd != 5'd0);
            dstreg_num  <= head.rd;
            write_value <= head.data;
            out_is_mem  <= 1'b1;
        end else begin
            reg_we      <= 1'b0;
            out_is_mem  <= 1'b0;
        end
    end

    // Scoreboard update: committed memory write clears, issue sets, set wins
    always_comb begin
        scoreboard_next = scoreboard;
        if (out_is_mem) begin
            scoreboard_next[dstreg_num] = 1'b0;
        end
        if (pend_set && (pend_rd != 5'd0)) begin
            scoreboard_next[pend_rd] = 1'b1;
        end
        scoreboard_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scoreboard <= '0;
        end else begin
            scoreboard <= scoreboard_next;
        end
    end

`ifdef WB_BYPASS_EN
    // Forward the value sitting in the write-port register and hide its busy
    always_comb begin
        fwd1_valid = reg_we && (dstreg_num == srcreg1_num) && (dstreg_num != 5'd0);
        fwd2_valid = reg_we && (dstreg_num == srcreg2_num) && (dstreg_num != 5'd0);
        fwd1_data  = write_value;
        fwd2_data  = write_value;
        busy1      = scoreboard[srcreg1_num] && (srcreg1_num != 5'd0) && !fwd1_valid;
        busy2      = scoreboard[srcreg2_num] && (srcreg2_num != 5'd0) && !fwd2_valid;
    end
`else
    // Operand busy straight from the scoreboard
    always_comb begin
        busy1 = scoreboard[srcreg1_num] && (srcreg1_num != 5'd0);
        busy2 = scoreboard[srcreg2_num] && (srcreg2_num != 5'd0);
    end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Testbench for regfile_writeback: directed scenarios plus randomized traffic,
// checked every cycle against a queue/array reference model.
module tb_regfile_writeback;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        pend_set;
    logic [4:0]  pend_rd;
    logic [4:0]  srcreg1_num, srcreg2_num;
    logic        busy1, busy2, reg_we;
    logic [4:0]  dstreg_num;
    logic [31:0] write_value;
    logic [2:0]  fifo_count;
`ifdef WB_BYPASS_EN
    logic        fwd1_valid, fwd2_valid;
    logic [31:0] fwd1_data, fwd2_data;
`endif

    regfile_writeback_if mif ();

    regfile_writeback #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem         (mif),
        .pend_set    (pend_set),
        .pend_rd     (pend_rd),
        .srcreg1_num (srcreg1_num),
        .srcreg2_num (srcreg2_num),
        .busy1       (busy1),
        .busy2       (busy2),
        .reg_we      (reg_we),
        .dstreg_num  (dstreg_num),
        .write_value (write_value),
        .fifo_count  (fifo_count)
`ifdef WB_BYPASS_EN
        ,
        .fwd1_valid  (fwd1_valid),
        .fwd1_data   (fwd1_data),
        .fwd2_valid  (fwd2_valid),
        .fwd2_data   (fwd2_data)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pending memory results, pending-register set, write port
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;
    ent_t        mq[$];
    bit          sb[32];
    bit          exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_val;
    bit          exp_mem;
    bit          last_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        foreach (sb[i]) sb[i] = 1'b0;
        exp_we  = 1'b0;
        exp_rd  = '0;
        exp_val = '0;
        exp_mem = 1'b0;
    endtask

    function automatic bit exp_fwd(input logic [4:0] s);
`ifdef WB_BYPASS_EN
        return exp_we && (exp_rd == s) && (s != 5'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_busy(input logic [4:0] s);
        return (s != 5'd0) && sb[s] && !exp_fwd(s);
    endfunction

    // One clock cycle: drive inputs after negedge, check outputs, advance model
    task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                         input bit mv, input logic [4:0] mrd, input logic [31:0] mdat,
                         input bit ps, input logic [4:0] prd,
                         input logic [4:0] s1, input logic [4:0] s2);
        ent_t e;
        alu_valid = av;  alu_rd = ard;  alu_data = adat;
        mif.mem_valid = mv;  mif.mem_rd = mrd;  mif.mem_data = mdat;
        pend_set = ps;  pend_rd = prd;
        srcreg1_num = s1;  srcreg2_num = s2;
        #1;
        chk("reg_we", 32'(reg_we), 32'(exp_we));
        if (exp_we) begin
            chk("dstreg_num", 32'(dstreg_num), 32'(exp_rd));
            chk("write_value", write_value, exp_val);
        end
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("mem_ready", 32'(mif.mem_ready), 32'(mq.size() < DEPTH));
        chk("busy1", 32'(busy1), 32'(exp_busy(s1)));
        chk("busy2", 32'(busy2), 32'(exp_busy(s2)));
`ifdef WB_BYPASS_EN
        chk("fwd1_valid", 32'(fwd1_valid), 32'(exp_fwd(s1)));
        chk("fwd2_valid", 32'(fwd2_valid), 32'(exp_fwd(s2)));
        if (exp_fwd(s1)) chk("fwd1_data", fwd1_data, exp_val);
        if (exp_fwd(s2)) chk("fwd2_data", fwd2_data, exp_val);
`endif
        last_acc = mv && (mq.size() < DEPTH);
        if (exp_mem) sb[exp_rd] = 1'b0;
        if (ps && prd != 5'd0) sb[prd] = 1'b1;
        if (av) begin
            exp_we = (ard != 5'd0); exp_rd = ard; exp_val = adat; exp_mem = 1'b0;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            exp_we = (e.rd != 5'd0); exp_rd = e.rd; exp_val = e.data; exp_mem = 1'b1;
        end else begin
            exp_we = 1'b0; exp_mem = 1'b0;
        end
        if (last_acc) begin
            e.rd = mrd; e.data = mdat;
            mq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, s1, s2);
    endtask

    initial begin
        int idx;
        bit r_av, r_mv, r_ps;
        logic [4:0] r_ard, r_mrd, r_prd;
        logic [31:0] r_adat, r_mdat;

        rst = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mif.mem_valid = 0; mif.mem_rd = 0; mif.mem_data = 0;
        pend_set = 0; pend_rd = 0; srcreg1_num = 0; srcreg2_num = 0;
        model_reset();
        #1;
        chk("rst_reg_we", 32'(reg_we), 32'd0);
        chk("rst_dstreg", 32'(dstreg_num), 32'd0);
        chk("rst_value", write_value, 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(mif.mem_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ALU single-cycle write
        cycle(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        chk("alu_we", 32'(reg_we), 32'd1);
        chk("alu_rd", 32'(dstreg_num), 32'd5);
        chk("alu_val", write_value, 32'h1234);
        idle(0, 0);
        chk("alu_we_off", 32'(reg_we), 32'd0);

        // Long-latency write to x7 with busy tracking
        cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        cycle(0, 0, 0, 1, 7, 32'hCAFEBABE, 0, 0, 7, 0);
        chk("pend7_busy_t1", 32'(busy1), 32'd1);
        idle(7, 0);
        chk("pend7_we", 32'(reg_we), 32'd1);
        chk("pend7_val", write_value, 32'hCAFEBABE);
`ifndef WB_BYPASS_EN
        chk("pend7_busy_t2", 32'(busy1), 32'd1);
`endif
        idle(7, 0);
        chk("pend7_busy_t3", 32'(busy1), 32'd0);

        // ALU starvation fills FIFO, then drain in order
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(1, 5'(20 + k), 32'(k), idx < 5, 5'(10 + idx), 32'hA000 + 32'(idx), 0, 0, 0, 0);
            if (last_acc) idx++;
        end
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_ready", 32'(mif.mem_ready), 32'd0);
        for (int k = 0; k < 8; k++) begin
            cycle(0, 0, 0, idx < 5, 5'(10 + idx), 32'hA000 + 32'(idx), 0, 0, 0, 0);
            if (last_acc) idx++;
        end
        chk("drain_all", 32'(idx), 32'd5);

        // x0 destination: consumed, never written
        cycle(0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        chk("x0_count", 32'(fifo_count), 32'd1);
        idle(0, 0);
        chk("x0_count0", 32'(fifo_count), 32'd0);
        chk("x0_we_a", 32'(reg_we), 32'd0);
        idle(0, 0);
        chk("x0_we_b", 32'(reg_we), 32'd0);
        chk("x0_busy", 32'(busy1), 32'd0);

        // Same-edge set and clear of x9: set wins
        cycle(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        cycle(0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0);
        idle(9, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        chk("x9_busy", 32'(busy1), 32'd1);
        idle(9, 0);

        // Mid-cycle reset with 3 entries queued and 2 pending bits
        cycle(0, 0, 0, 0, 0, 0, 1, 11, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
        for (int k = 0; k < 3; k++) cycle(1, 1, 0, 1, 5'(13 + k), 32'(k), 0, 0, 11, 12);
        chk("pre_rst_count", 32'(fifo_count), 32'd3);
        alu_valid = 0; mif.mem_valid = 0; pend_set = 0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(reg_we), 32'd0);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_ready", 32'(mif.mem_ready), 32'd1);
        chk("mid_rst_busy1", 32'(busy1), 32'd0);
        chk("mid_rst_busy2", 32'(busy2), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) idle(11, 12);

        // ALU write seen through the forwarding path
        cycle(1, 3, 32'h3333, 0, 0, 0, 0, 0, 0, 3);
`ifdef WB_BYPASS_EN
        chk("fwd2_valid_dir", 32'(fwd2_valid), 32'd1);
        chk("fwd2_data_dir", fwd2_data, 32'h3333);
`endif
        idle(0, 3);

        // Randomized traffic
        r_mv = 0; r_mrd = 0; r_mdat = 0; last_acc = 0;
        for (int k = 0; k < 1500; k++) begin
            r_av   = ($urandom_range(0, 9) < 3);
            r_ard  = 5'($urandom_range(0, 7));
            r_adat = $urandom;
            if (!(r_mv && !last_acc)) begin
                r_mv   = ($urandom_range(0, 9) < 6);
                r_mrd  = 5'($urandom_range(0, 7));
                r_mdat = $urandom;
            end
            r_ps  = ($urandom_range(0, 9) < 2);
            r_prd = 5'($urandom_range(0, 7));
            cycle(r_av, r_ard, r_adat, r_mv, r_mrd, r_mdat, r_ps, r_prd,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side driver for the 32x32 register file. Merges single-cycle ALU results and handshaked memory/long-latency results into the single register-file write port (`reg_we`, `dstreg_num`, `write_value`). Keeps a pending-register scoreboard so decode can stall on operands whose long-latency write has not yet landed. Sits between the execute/memory stages and the register file.

## Interface
- `FIFO_DEPTH`, 4, memory-result buffer entries (power of two, >= 2)
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `alu_valid`  in  1  ALU result present this cycle (no backpressure)
- `alu_rd`  in  5  ALU destination register
- `alu_data`  in  32  ALU result
- `mem_valid`  in  1  memory result offered
- `mem_ready`  out  1  FIFO can accept; equals !full
- `mem_rd`  in  5  memory-result destination
- `mem_data`  in  32  memory result
- `pend_set`  in  1  long-latency op issued; mark `pend_rd` pending
- `pend_rd`  in  5  register to mark pending
- `srcreg1_num`, `srcreg2_num`  in  5  decode operand numbers
- `busy1`, `busy2`  out  1  combinational: operand register pending
- `reg_we`  out  1  registered write enable to register file
- `dstreg_num`  out  5  registered write address
- `write_value`  out  32  registered write data
- `fifo_count`  out  log2(FIFO_DEPTH)+1  entries held

## Operation
- Each cycle select one source for the write-port register: `alu_valid` wins; otherwise pop the FIFO head if non-empty; otherwise `reg_we` <= 0.
- FIFO push on `mem_valid && mem_ready`; push and pop in the same cycle allowed; count unchanged.
- Full FIFO: `mem_ready`=0; producer holds `mem_*` stable. Push while full is impossible by construction.
- Continuous `alu_valid` starves the FIFO; this is intended (the ALU cannot stall).
- Destination x0: entry consumed normally, but `reg_we` stays 0. `pend_set` with `pend_rd`=0 is ignored. `busy` for x0 is always 0.
- Scoreboard: 32 bits. Set on `pend_set`. Cleared on the edge where a write-port register holding a popped memory entry (internal flag `out_is_mem`=1) is committed, i.e. the same edge on which the register file writes.
- Same-edge set and clear of one register: set wins.
- ALU writes never touch the scoreboard.
- Pointer wrap: read/write pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset (async assert, released synchronously by the next edge): `reg_we`=0, `dstreg_num`=0, `write_value`=0, FIFO empty, `fifo_count`=0, `mem_ready`=1, scoreboard clear, `busy1`=`busy2`=0.
- Reset mid-operation discards FIFO contents and pending bits immediately.
- ALU latency: result at cycle t -> `reg_we`=1 during t+1 -> register file updated at the end of t+1.
- Memory latency: accepted at t -> earliest `reg_we` at t+2; `busy` falls at t+3, when the register file already holds the value.
- `busy` is combinational from the scoreboard and the source numbers; it is 1 while the write sits in the output register.

## Configuration
- `WB_BYPASS_EN` defined: adds outputs `fwd1_valid`, `fwd1_data[31:0]`, `fwd2_valid`, `fwd2_data[31:0]`.
  - `fwdN_valid` = `reg_we && dstreg_num == srcregN_num && dstreg_num != 0`; `fwdN_data` = `write_value`.
  - `busyN` is forced to 0 when `fwdN_valid`=1.
- Undefined: the forwarding ports are absent and `busy` follows the scoreboard only.

## Test plan
- Reset then `alu_valid`=1, `alu_rd`=5, `alu_data`=0x1234 at t -> `reg_we`=1, `dstreg_num`=5, `write_value`=0x1234 at t+1; `reg_we`=0 at t+2.
- `pend_set` with rd=7; memory writes 0xCAFEBABE to rd 7 with ALU idle -> `busy1`=1 (srcreg1=7) until the commit edge; `reg_we` with value 0xCAFEBABE appears 2 cycles after accept; `busy1`=0 the cycle after.
- Hold `alu_valid`=1 for 6 cycles while offering 5 memory results -> `mem_ready` drops after 4 pushes and `fifo_count`=4; when ALU goes idle, 4 writes drain in FIFO order, then the 5th is accepted and written.
- Memory result to x0 with data 0xFFFFFFFF -> `fifo_count` increments then decrements, `reg_we` never asserts; `pend_set` rd=0 leaves `busy`=0.
- `pend_set` rd=9 on the same edge as a commit clearing rd 9 -> `busy` for 9 stays 1.
- Assert `rst` with 3 FIFO entries and 2 pending bits -> all outputs at reset values immediately; no further writes. With `WB_BYPASS_EN`: ALU write rd=3 and `srcreg2_num`=3 -> `fwd2_valid`=1, `fwd2_data` equals the written value during the `reg_we` cycle.
